regfile_wb_arbiter: RTL and testbench

//   Round-robin arbiter sharing the register file's single write port between NUM_REQ writeback sources
//   (ALU, load unit, CSR, ...). Each source presents addr/data under a valid/ready handshake.
//   The winning write is registered and driven onto write_address/write_value/write_enable of registerfile.

---
 rtl/regfile_wb_arbiter.sv | 101 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port among NUM_REQ writeback sources.
// Optional same-cycle read bypass of the in-flight write when REGFILE_FWD_EN is defined.
module regfile_wb_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         stall,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
`ifdef REGFILE_FWD_EN
  input  logic [ADDR_W-1:0]            fwd_addr_1,
  input  logic [ADDR_W-1:0]            fwd_addr_2,
  input  logic [DATA_W-1:0]            rf_data_1,
  input  logic [DATA_W-1:0]            rf_data_2,
  output logic [DATA_W-1:0]            fwd_data_1,
  output logic [DATA_W-1:0]            fwd_data_2,
`endif
  output logic [ADDR_W-1:0]            write_address,
  output logic [DATA_W-1:0]            write_value,
  output logic                         write_enable,
  output logic [$clog2(NUM_REQ)-1:0]   grant_idx
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  logic [IdxW-1:0]   rr_ptr_q;
  logic [IdxW-1:0]   grant_sel;
  logic              grant_valid;
  logic [IdxW-1:0]   next_ptr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              wr_en_q;
  logic [IdxW-1:0]   grant_idx_q;

  // Scan sources starting at rr_ptr, wrapping; first valid source wins.
  always_comb begin
    int unsigned cand;
    logic [IdxW-1:0] cand_idx;
    cand        = 0;
    cand_idx    = '0;
    grant_valid = 1'b0;
    grant_sel   = '0;
    req_ready   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IdxW'(cand);
      if (!grant_valid && req_valid[cand_idx]) begin
        grant_valid = 1'b1;
        grant_sel   = cand_idx;
      end
    end
    if (stall || !rst_n) grant_valid = 1'b0;
    if (grant_valid) req_ready[grant_sel] = 1'b1;
  end

  always_comb begin
    next_ptr = (grant_sel == IdxW'(NUM_REQ - 1)) ? '0 : grant_sel + IdxW'(1);
    sel_addr = req_addr[32'(grant_sel) * ADDR_W +: ADDR_W];
    sel_data = req_data[32'(grant_sel) * DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      grant_idx_q <= '0;
    end else if (grant_valid) begin
      rr_ptr_q    <= next_ptr;
      wr_addr_q   <= sel_addr;
      wr_data_q   <= sel_data;
      grant_idx_q <= grant_sel;
      // x0 is hardwired zero: accept the request but never strobe the write
      wr_en_q     <= (sel_addr != '0);
    end else begin
      wr_en_q     <= 1'b0;
    end
  end

  assign write_address = wr_addr_q;
  assign write_value   = wr_data_q;
  assign write_enable  = wr_en_q;
  assign grant_idx     = grant_idx_q;

`ifdef REGFILE_FWD_EN
  assign fwd_data_1 = (wr_en_q && fwd_addr_1 == wr_addr_q && fwd_addr_1 != '0) ? wr_data_q
                                                                                : rf_data_1;
  assign fwd_data_2 = (wr_en_q && fwd_addr_2 == wr_addr_q && fwd_addr_2 != '0) ? wr_data_q
                                                                                : rf_data_2;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level reference model of the arbitration rules.
module tb_regfile_wb_arbiter;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic          stall;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [AW-1:0] write_address;
  logic [DW-1:0] write_value;
  logic          write_enable;
  logic [1:0]    grant_idx;
`ifdef REGFILE_FWD_EN
  logic [AW-1:0] fwd_addr_1, fwd_addr_2;
  logic [DW-1:0] rf_data_1, rf_data_2, fwd_data_1, fwd_data_2;
`endif

  regfile_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_data     (req_data),
`ifdef REGFILE_FWD_EN
    .fwd_addr_1   (fwd_addr_1),
    .fwd_addr_2   (fwd_addr_2),
    .rf_data_1    (rf_data_1),
    .rf_data_2    (rf_data_2),
    .fwd_data_1   (fwd_data_1),
    .fwd_data_2   (fwd_data_2),
`endif
    .write_address(write_address),
    .write_value  (write_value),
    .write_enable (write_enable),
    .grant_idx    (grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          m_ptr;
  logic        m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_val;
  int          m_gidx;
  int          last_win;

  function automatic void model_reset();
    m_ptr = 0; m_we = 1'b0; m_addr = '0; m_val = '0; m_gidx = 0;
  endfunction

  function automatic int model_winner();
    if (stall || !rst_n) return -1;
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int w;
    logic [N-1:0] r;
    w = model_winner();
    r = '0;
    if (w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  function automatic logic [AW+DW+3-1:0] exp_out();
    return {m_we, m_addr, m_val, 2'(m_gidx)};
  endfunction

  // Advance one clock and update the model from the inputs present at the edge.
  task automatic tick();
    int w;
    w = model_winner();
    @(posedge clk);
    if (w >= 0) begin
      m_addr = req_addr[w*AW +: AW];
      m_val  = req_data[w*DW +: DW];
      m_we   = (m_addr != 0);
      m_gidx = w;
      m_ptr  = (w + 1) % N;
    end else begin
      m_we = 1'b0;
    end
    last_win = w;
    #1;
  endtask

  task automatic set_src(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; req_valid = 3'b111;
    req_addr = '0; req_data = '0;
    for (int i = 0; i < N; i++) set_src(i, AW'(i + 7), DW'(i + 1000));
`ifdef REGFILE_FWD_EN
    fwd_addr_1 = '0; fwd_addr_2 = '0; rf_data_1 = '0; rf_data_2 = '0;
`endif
    model_reset();
    repeat (3) @(negedge clk);
    total++;
    if (req_ready !== 3'b000) begin
      bad++; $display("FAIL reset_ready got=%b exp=000", req_ready);
    end
    total++;
    if ({write_enable, write_address, write_value, grant_idx} !== '0) begin
      bad++; $display("FAIL reset_outputs got=%b/%h/%h/%0d exp=0", write_enable, write_address,
                      write_value, grant_idx);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (req_ready !== 3'b001) begin
      bad++; $display("FAIL reset_first_grant got=%b exp=001", req_ready);
    end
    tick();
    total++;
    if ({write_enable, write_address, write_value, grant_idx} !== exp_out()) begin
      bad++; $display("FAIL reset_first_write got=%h exp=%h",
                      {write_enable, write_address, write_value, grant_idx}, exp_out());
    end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_single();
    @(negedge clk);
    set_src(1, 5'd2, 32'd100);
    req_valid = 3'b010;
    #1;
    total++;
    if (req_ready !== 3'b010) begin
      bad++; $display("FAIL single_ready got=%b exp=010", req_ready);
    end
    tick();
    total++;
    if ({write_enable, write_address, write_value, grant_idx} !== {1'b1, 5'd2, 32'd100, 2'd1})
    begin
      bad++; $display("FAIL single_write got=%b/%0d/%0d/%0d exp=1/2/100/1", write_enable,
                      write_address, write_value, grant_idx);
    end
    @(negedge clk);
    req_valid = '0;
    tick();
    total++;
    if ({write_enable, write_address, write_value, grant_idx} !== {1'b0, 5'd2, 32'd100, 2'd1})
    begin
      bad++; $display("FAIL single_hold got=%b/%0d/%0d/%0d exp=0/2/100/1", write_enable,
                      write_address, write_value, grant_idx);
    end
  endtask

  task automatic test_contention();
    int order[$];
    @(negedge clk);
    for (int i = 0; i < N; i++) set_src(i, AW'(i + 1), DW'(32'hA000 + i));
    req_valid = 3'b111;
    for (int c = 0; c < N; c++) begin
      #1;
      total++;
      if (req_ready !== exp_ready()) begin
        bad++; $display("FAIL contention_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready());
      end
      tick();
      order.push_back(last_win);
      total++;
      if ({write_enable, write_address, write_value, grant_idx} !== exp_out() || !write_enable)
      begin
        bad++; $display("FAIL contention_write c=%0d got=%h exp=%h", c,
                        {write_enable, write_address, write_value, grant_idx}, exp_out());
      end
      @(negedge clk);
      if (last_win >= 0) req_valid[last_win] = 1'b0;
    end
    // Every source granted exactly once in rotation
    total++;
    if (order.size() != N || order[1] != (order[0] + 1) % N || order[2] != (order[0] + 2) % N)
    begin
      bad++; $display("FAIL contention_order got=%p exp=rotation", order);
    end
    req_valid = '0;
  endtask

  task automatic test_x0();
    @(negedge clk);
    // Park pointer at 0 first via a grant to source 2
    set_src(2, 5'd9, 32'd55);
    req_valid = 3'b100;
    tick();
    @(negedge clk);
    set_src(0, 5'd0, 32'd100);
    req_valid = 3'b001;
    #1;
    total++;
    if (req_ready !== 3'b001) begin
      bad++; $display("FAIL x0_ready got=%b exp=001", req_ready);
    end
    tick();
    total++;
    if ({write_enable, write_address, write_value, grant_idx} !== {1'b0, 5'd0, 32'd100, 2'd0})
    begin
      bad++; $display("FAIL x0_write got=%b/%0d/%0d/%0d exp=0/0/100/0", write_enable,
                      write_address, write_value, grant_idx);
    end
    @(negedge clk);
    req_valid = 3'b111;
    for (int i = 0; i < N; i++) set_src(i, AW'(i + 4), DW'(i));
    #1;
    total++;
    if (req_ready !== 3'b010) begin
      bad++; $display("FAIL x0_ptr_advance got=%b exp=010", req_ready);
    end
    tick();
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_stall();
    @(negedge clk);
    set_src(2, 5'd17, 32'h1234_5678);
    req_valid = 3'b100;
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (req_ready !== 3'b000) begin
        bad++; $display("FAIL stall_ready c=%0d got=%b exp=000", c, req_ready);
      end
      tick();
      total++;
      if (write_enable !== 1'b0) begin
        bad++; $display("FAIL stall_no_write c=%0d got=%b exp=0", c, write_enable);
      end
      @(negedge clk);
    end
    stall = 1'b0;
    #1;
    total++;
    if (req_ready !== 3'b100) begin
      bad++; $display("FAIL stall_release_ready got=%b exp=100", req_ready);
    end
    tick();
    total++;
    if ({write_enable, write_address, write_value, grant_idx} !==
        {1'b1, 5'd17, 32'h1234_5678, 2'd2}) begin
      bad++; $display("FAIL stall_release_write got=%b/%0d/%h/%0d exp=1/17/12345678/2",
                      write_enable, write_address, write_value, grant_idx);
    end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_random();
    logic pend [N];
    int errs_ready, errs_out;
    errs_ready = 0; errs_out = 0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          set_src(i, ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom_range(1, 31)),
                  DW'($urandom));
        end
        req_valid[i] = pend[i];
      end
      stall = ($urandom_range(0, 4) == 0);
      #1;
      total++;
      if (req_ready !== exp_ready()) begin
        bad++; errs_ready++;
        if (errs_ready < 5) $display("FAIL random_ready c=%0d got=%b exp=%b", c, req_ready,
                                     exp_ready());
      end
      tick();
      if (last_win >= 0) pend[last_win] = 1'b0;
      total++;
      if ({write_enable, write_address, write_value, grant_idx} !== exp_out()) begin
        bad++; errs_out++;
        if (errs_out < 5) $display("FAIL random_out c=%0d got=%h exp=%h", c,
                                   {write_enable, write_address, write_value, grant_idx},
                                   exp_out());
      end
    end
    @(negedge clk);
    req_valid = '0; stall = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    @(negedge clk);
    set_src(0, 5'd3, 32'hCAFE);
    set_src(1, 5'd4, 32'hBEEF);
    set_src(2, 5'd6, 32'hF00D);
    req_valid = 3'b111;
    tick();
    total++;
    if (write_enable !== 1'b1) begin
      bad++; $display("FAIL midrst_pre got=%b exp=1", write_enable);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if ({req_ready, write_enable, write_address, write_value, grant_idx} !== '0) begin
      bad++; $display("FAIL midrst_clear got=%b/%b/%h/%h/%0d exp=0", req_ready, write_enable,
                      write_address, write_value, grant_idx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (req_ready !== exp_ready()) begin
      bad++; $display("FAIL midrst_regrant got=%b exp=%b", req_ready, exp_ready());
    end
    tick();
    @(negedge clk);
    req_valid = '0;
  endtask

`ifdef REGFILE_FWD_EN
  task automatic test_fwd();
    @(negedge clk);
    set_src(0, 5'd5, 32'hDEAD_BEEF);
    req_valid = 3'b001;
    for (int g = 0; g < N && req_ready[0] !== 1'b1; g++) begin
      #1;
      if (req_ready[0] !== 1'b1) tick();
      @(negedge clk);
    end
    tick();
    fwd_addr_1 = 5'd5; fwd_addr_2 = 5'd0;
    rf_data_1 = 32'h1111_1111; rf_data_2 = 32'h2222_2222;
    #1;
    total++;
    if (fwd_data_1 !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL fwd_hit got=%h exp=deadbeef", fwd_data_1);
    end
    total++;
    if (fwd_data_2 !== 32'h2222_2222) begin
      bad++; $display("FAIL fwd_x0 got=%h exp=22222222", fwd_data_2);
    end
    @(negedge clk);
    req_valid = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_x0();
    test_stall();
    test_random();
    test_reset_mid_write();
`ifdef REGFILE_FWD_EN
    test_fwd();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
